// File: rtl/fsm_req_issuer.sv
// Command queue feeding fsm_controller: one wr_en/rd_en pulse per queued
// command, issued only while the controller sits in IDLE, with timeout tracking.
module fsm_req_issuer #(
    parameter int         DEPTH     = 4,
    parameter logic [2:0] IDLE_CODE = 3'b000,
    parameter int         TIMEOUT   = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     cmd_valid,
    input  logic                     cmd_is_rd,
    output logic                     cmd_ready,
    input  logic [2:0]               state,
    output logic                     wr_en,
    output logic                     rd_en,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        ACK  = 2'd1,
        DONE = 2'd2
    } st_t;

    st_t              r_st;
    st_t              w_st_nxt;
    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_nxt;
    logic             r_wr_en;
    logic             r_rd_en;
    logic             r_busy;
    logic             r_timeout_err;

    logic             w_idle;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_head;
    logic             w_fire_wr;
    logic             w_fire_rd;
    logic             w_timeout;

    assign w_idle    = (state == IDLE_CODE);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push    = cmd_valid && !w_full;
    assign w_head    = r_mem[r_rd_ptr];

    assign cmd_ready   = !w_full;
    assign pending     = r_count;
    assign wr_en       = r_wr_en;
    assign rd_en       = r_rd_en;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

    always_comb begin
        w_st_nxt    = r_st;
        w_timer_nxt = r_timer;
        w_pop       = 1'b0;
        w_fire_wr   = 1'b0;
        w_fire_rd   = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_st)
            ARM: begin
                if (r_count != '0 && enable && w_idle) begin
                    w_pop       = 1'b1;
                    w_fire_rd   = w_head;
                    w_fire_wr   = !w_head;
                    w_timer_nxt = '0;
                    w_st_nxt    = ACK;
                end
            end
            ACK: begin
                if (!w_idle) begin
                    w_st_nxt = DONE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                    // Controller never left IDLE: drop the command, no retry.
                    if (w_timer_nxt == TW'(TIMEOUT)) begin
                        w_timeout = 1'b1;
                        w_st_nxt  = ARM;
                    end
                end
            end
            DONE: begin
                if (w_idle) begin
                    w_st_nxt = ARM;
                end
            end
            default: begin
                w_st_nxt = ARM;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_st          <= ARM;
            r_timer       <= '0;
            r_wr_en       <= 1'b0;
            r_rd_en       <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_st    <= w_st_nxt;
            r_timer <= w_timer_nxt;
            r_wr_en <= w_fire_wr;
            r_rd_en <= w_fire_rd;
            r_busy  <= (w_st_nxt != ARM);
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_is_rd;
        end
    end

endmodule

// File: tb/tb_fsm_req_issuer.sv
// Directed bench for fsm_req_issuer with a transaction-level reference model
// and a responder standing in for fsm_controller.
module tb_fsm_req_issuer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
    localparam int PW      = $clog2(DEPTH) + 1;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          enable    = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_is_rd = 1'b0;
    logic [2:0]    state     = 3'b000;
    logic          cmd_ready;
    logic          wr_en;
    logic          rd_en;
    logic          busy;
    logic          timeout_err;
    logic [PW-1:0] pending;

    always #5 clock = ~clock;

    fsm_req_issuer #(
        .DEPTH(DEPTH),
        .IDLE_CODE(3'b000),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .cmd_valid(cmd_valid),
        .cmd_is_rd(cmd_is_rd),
        .cmd_ready(cmd_ready),
        .state(state),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .busy(busy),
        .pending(pending),
        .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Controller stand-in: leaves IDLE one cycle after a pulse, stays out two cycles.
    bit resp_on  = 1'b1;
    int resp_cnt = 0;

    always @(negedge clock) begin
        if (reset) begin
            resp_cnt = 0;
            state    = 3'b000;
        end else if (resp_cnt == 1) begin
            state    = 3'b001;
            resp_cnt = 2;
        end else if (resp_cnt == 2) begin
            resp_cnt = 3;
        end else if (resp_cnt == 3) begin
            state    = 3'b000;
            resp_cnt = 0;
        end else if (resp_on && (wr_en || rd_en)) begin
            resp_cnt = 1;
        end
    end

    // Reference model: command queue plus "waiting for controller" flags.
    bit       mq[$];
    bit       m_wr, m_rd, m_to;
    bit       m_leave, m_back;
    int       m_idle;
    logic [2:0] st_at_edge;

    always @(posedge clock) begin
        bit can_push;
        bit c;
        st_at_edge = state;
        if (reset) begin
            mq.delete();
            m_wr = 0; m_rd = 0; m_to = 0;
            m_leave = 0; m_back = 0; m_idle = 0;
        end else begin
            can_push = cmd_valid && (mq.size() < DEPTH);
            m_wr = 0;
            m_rd = 0;
            if (!m_leave && !m_back) begin
                if (mq.size() > 0 && enable && state == 3'b000) begin
                    c = mq.pop_front();
                    m_rd = c;
                    m_wr = !c;
                    m_leave = 1;
                    m_idle = 0;
                end
            end else if (m_leave) begin
                if (state != 3'b000) begin
                    m_leave = 0;
                    m_back = 1;
                end else begin
                    m_idle++;
                    if (m_idle >= TIMEOUT) begin
                        m_to = 1;
                        m_leave = 0;
                    end
                end
            end else if (state == 3'b000) begin
                m_back = 0;
            end
            if (can_push) mq.push_back(cmd_is_rd);
        end
    end

    int cyc       = 0;
    bit prev_puls = 0;
    bit plog[$];
    int n_pulse   = 0;
    int pulse_cyc = -1;
    int to_cyc    = -1;
    int to_gap    = -1;

    always @(posedge clock) begin
        #1;
        cyc++;
        chk("wr_en", wr_en, m_wr);
        chk("rd_en", rd_en, m_rd);
        chk("busy", busy, m_leave || m_back);
        chk("pending", pending, mq.size());
        chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
        chk("timeout_err", timeout_err, m_to);
        if (wr_en || rd_en) begin
            if (wr_en && rd_en) chk("both_en", 1, 0);
            if (prev_puls) chk("pulse_width", 2, 1);
            chk("issue_state", st_at_edge, 0);
            plog.push_back(rd_en);
            n_pulse++;
            pulse_cyc = cyc;
        end
        prev_puls = wr_en || rd_en;
        if (timeout_err && to_cyc < 0) begin
            to_cyc = cyc;
            to_gap = cyc - pulse_cyc;
        end
    end

    function automatic int log_code();
        int code = 0;
        foreach (plog[i]) code = code * 10 + (plog[i] ? 2 : 1);
        return code;
    endfunction

    task automatic push(input bit rd);
        cmd_valid = 1'b1;
        cmd_is_rd = rd;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clr_log();
        plog.delete();
        n_pulse = 0;
    endtask

    initial begin
        int snap;
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        run(1);
        chk("t1_wr_en", wr_en, 0);
        chk("t1_rd_en", rd_en, 0);
        chk("t1_busy", busy, 0);
        chk("t1_pending", pending, 0);
        chk("t1_cmd_ready", cmd_ready, 1);
        chk("t1_timeout", timeout_err, 0);

        enable = 1'b1;
        clr_log();
        push(0);
        run(12);
        chk("t2_pulses", n_pulse, 1);
        chk("t2_order", log_code(), 1);
        chk("t2_busy_after", busy, 0);

        enable = 1'b0;
        clr_log();
        push(0);
        push(1);
        push(0);
        chk("t3_pending", pending, 3);
        enable = 1'b1;
        run(30);
        chk("t3_pulses", n_pulse, 3);
        chk("t3_order", log_code(), 121);

        enable = 1'b0;
        clr_log();
        push(1);
        push(0);
        push(1);
        push(0);
        push(1);
        chk("t4_pending_full", pending, 4);
        chk("t4_cmd_ready", cmd_ready, 0);
        chk("t4_no_pulses", n_pulse, 0);
        enable = 1'b1;
        run(40);
        chk("t4_pulses", n_pulse, 4);
        chk("t4_order", log_code(), 2121);
        chk("t4_pending_end", pending, 0);

        resp_on = 1'b0;
        to_cyc  = -1;
        clr_log();
        push(0);
        push(1);
        run(40);
        chk("t5_timeout", timeout_err, 1);
        chk("t5_gap", to_gap, TIMEOUT);
        chk("t5_pulses", n_pulse, 2);
        chk("t5_order", log_code(), 12);
        chk("t5_pending", pending, 0);
        run(5);
        chk("t5_sticky", timeout_err, 1);

        enable = 1'b0;
        push(0);
        push(1);
        push(0);
        enable = 1'b1;
        run(1);
        chk("t6_pending_ack", pending, 2);
        chk("t6_busy_ack", busy, 1);
        chk("t6_wr_pulse", wr_en, 1);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        chk("t6_pending_rst", pending, 0);
        chk("t6_busy_rst", busy, 0);
        chk("t6_wr_rst", wr_en, 0);
        chk("t6_to_rst", timeout_err, 0);
        snap = n_pulse;
        run(10);
        chk("t6_no_pulses", n_pulse, snap);

        resp_on = 1'b1;
        enable  = 1'b0;
        clr_log();
        push(1);
        push(1);
        push(0);
        chk("t6_pending3", pending, 3);
        enable = 1'b1;
        push(0);
        chk("t6_pushpop", pending, 3);
        chk("t6_pushpop_rd", rd_en, 1);
        run(40);
        chk("t6_order", log_code(), 2211);
        chk("t6_pending_end", pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
